// File: rtl/inv_shift_rows_collect.sv
// Column-serial collector with InvShiftRows folded into the write permutation.
// Define INV_SHIFT_ROWS_PINGPONG_EN for the double-buffered variant.
module inv_shift_rows_collect (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [31:0]  col_in,
    input  logic         col_valid,
    output logic         col_ready,
    output logic [127:0] state_out,
    output logic         state_valid,
    input  logic         state_ready,
    output logic         busy
);

    // Byte in[r][c] lands at out[r][(c+r) mod 4]; row r of a column is col[31-8r -: 8].
    function automatic logic [127:0] write_col(input logic [127:0] cur,
                                               input logic [1:0]   c,
                                               input logic [31:0]  col);
        logic [127:0] res;
        logic [1:0]   oc;
        res = cur;
        for (int r = 0; r < 4; r++) begin
            oc = c + 2'(r);
            res[127 - 32*int'(oc) - 8*r -: 8] = col[31 - 8*r -: 8];
        end
        return res;
    endfunction

    logic [1:0] col_cnt_q, col_cnt_d;
    logic       col_accept;
    logic       out_accept;
    logic       last_col;

    assign col_accept = col_valid && col_ready;
    assign out_accept = state_valid && state_ready;
    assign last_col   = col_accept && (col_cnt_q == 2'd3);
    assign busy       = (col_cnt_q != 2'd0);

`ifdef INV_SHIFT_ROWS_PINGPONG_EN

    logic [1:0][127:0] buf_q, buf_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        full_cnt_q, full_cnt_d;

    assign col_ready   = (full_cnt_q < 2'd2);
    assign state_valid = (full_cnt_q != 2'd0);
    assign state_out   = buf_q[rd_ptr_q];

    always_comb begin
        buf_d      = buf_q;
        col_cnt_d  = col_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        full_cnt_d = full_cnt_q;
        if (clear) begin
            col_cnt_d  = 2'd0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            full_cnt_d = 2'd0;
        end else begin
            if (col_accept) begin
                buf_d[wr_ptr_q] = write_col(buf_q[wr_ptr_q], col_cnt_q, col_in);
                col_cnt_d       = col_cnt_q + 2'd1;
                if (last_col) begin
                    wr_ptr_d = ~wr_ptr_q;
                end
            end
            if (out_accept) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            // Simultaneous completion and release leaves the count unchanged.
            case ({last_col, out_accept})
                2'b10:   full_cnt_d = full_cnt_q + 2'd1;
                2'b01:   full_cnt_d = full_cnt_q - 2'd1;
                default: full_cnt_d = full_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            col_cnt_q  <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            full_cnt_q <= 2'd0;
        end else begin
            buf_q      <= buf_d;
            col_cnt_q  <= col_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_cnt_q <= full_cnt_d;
        end
    end

`else

    typedef enum logic [0:0] {StFill, StHold} state_e;

    state_e       state_q, state_d;
    logic [127:0] buf_q, buf_d;

    assign col_ready   = (state_q == StFill);
    assign state_valid = (state_q == StHold);
    assign state_out   = buf_q;

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        buf_d     = buf_q;
        if (clear) begin
            state_d   = StFill;
            col_cnt_d = 2'd0;
        end else begin
            case (state_q)
                StFill: begin
                    if (col_accept) begin
                        buf_d     = write_col(buf_q, col_cnt_q, col_in);
                        col_cnt_d = col_cnt_q + 2'd1;
                        if (last_col) begin
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (out_accept) begin
                        state_d   = StFill;
                        col_cnt_d = 2'd0;
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFill;
            col_cnt_q <= 2'd0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            buf_q     <= buf_d;
        end
    end

`endif

endmodule

// File: tb/tb_inv_shift_rows_collect.sv
// Scoreboard bench for inv_shift_rows_collect: driver pushes expected blocks,
// a negedge monitor pops and compares on every output handshake.
module tb_inv_shift_rows_collect;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic [31:0]  col_in;
    logic         col_valid;
    logic         col_ready;
    logic [127:0] state_out;
    logic         state_valid;
    logic         state_ready;
    logic         busy;

    int n_cmp;
    int n_mis;
    int n_blocks;
    int cycle;
    int last_hs;
    int hs_interval;
    bit rand_ready;

    logic [127:0] exp_q[$];

`ifdef INV_SHIFT_ROWS_PINGPONG_EN
    localparam int BlockPeriod = 4;
    localparam logic HoldColReady = 1'b1;
`else
    localparam int BlockPeriod = 5;
    localparam logic HoldColReady = 1'b0;
`endif

    inv_shift_rows_collect dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .col_in      (col_in),
        .col_valid   (col_valid),
        .col_ready   (col_ready),
        .state_out   (state_out),
        .state_valid (state_valid),
        .state_ready (state_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Gather-form reference: out[r][c] = in[r][(c - r) mod 4].
    function automatic logic [127:0] model(input logic [31:0] c0, input logic [31:0] c1,
                                           input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0]  cols[4];
        logic [127:0] res;
        cols[0] = c0; cols[1] = c1; cols[2] = c2; cols[3] = c3;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 32*c - 8*r -: 8] = cols[(c - r + 4) % 4][31 - 8*r -: 8];
            end
        end
        return res;
    endfunction

    always @(negedge clk) begin
        cycle++;
        if (rst_n && state_valid && state_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_block: got %h expected none", state_out);
            end else begin
                check("block", state_out, exp_q.pop_front());
            end
            n_blocks++;
            hs_interval = cycle - last_hs;
            last_hs = cycle;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) state_ready = 1'($urandom_range(0, 1));
    endtask

    // Called and returns at posedge+1.
    task automatic send_col(input logic [31:0] c);
        int n;
        n = 0;
        col_in = c;
        col_valid = 1'b1;
        @(negedge clk);
        while (!col_ready && n < 100) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (!col_ready) begin
            n_cmp++;
            n_mis++;
            $display("FAIL col_timeout: got col_ready=0 expected 1 within 100 cycles");
        end
        tick();
        col_valid = 1'b0;
    endtask

    task automatic send_block(input logic [31:0] c0, input logic [31:0] c1,
                              input logic [31:0] c2, input logic [31:0] c3,
                              input logic [127:0] exp, input bit push);
        if (push) exp_q.push_back(exp);
        send_col(c0);
        send_col(c1);
        send_col(c2);
        send_col(c3);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rand_ready = 1'b0;
        state_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        tick();
    endtask

    localparam logic [127:0] ExpT1  = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [127:0] ExpRep = {4{32'h11223344}};
    localparam logic [127:0] ExpDia = 128'haa00000000bb00000000cc00000000dd;

    initial begin
        logic [127:0] held;
        logic [31:0]  r0, r1, r2, r3;
        int           blk0;
        n_cmp = 0; n_mis = 0; n_blocks = 0; cycle = 0; last_hs = 0; hs_interval = 0;
        rand_ready = 1'b0;
        rst_n = 1'b0; clear = 1'b0; col_in = '0; col_valid = 1'b0; state_ready = 1'b0;
        #23;
        check("rst_col_ready", 128'(col_ready), 128'd1);
        check("rst_state_valid", 128'(state_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_state_out", state_out, 128'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Directed block, single-cycle valid with ready high.
        state_ready = 1'b1;
        exp_q.push_back(ExpT1);
        send_col(32'h00010203);
        send_col(32'h04050607);
        check("busy_partial", 128'(busy), 128'd1);
        send_col(32'h08090a0b);
        send_col(32'h0c0d0e0f);
        check("t1_valid_rise", 128'(state_valid), 128'd1);
        check("t1_out", state_out, ExpT1);
        tick();
        check("t1_valid_fall", 128'(state_valid), 128'd0);
        drain();

        // Held output stays stable.
        state_ready = 1'b0;
        send_block(32'h11223344, 32'h11223344, 32'h11223344, 32'h11223344, ExpRep, 1'b1);
        held = state_out;
        for (int i = 0; i < 3; i++) tick();
        check("hold_valid", 128'(state_valid), 128'd1);
        check("hold_out", state_out, ExpRep);
        check("hold_stable", state_out, held);
        check("hold_col_ready", 128'(col_ready), 128'(HoldColReady));
`ifdef INV_SHIFT_ROWS_PINGPONG_EN
        send_block(32'haabbccdd, 32'h0, 32'h0, 32'h0, ExpDia, 1'b1);
        check("pp_full_col_ready", 128'(col_ready), 128'd0);
        check("pp_full_out", state_out, ExpRep);
`endif
        drain();

        // Clear discards a partial block.
        send_col(32'hdeadbeef);
        send_col(32'h01234567);
        check("pre_clear_busy", 128'(busy), 128'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_busy", 128'(busy), 128'd0);
        check("clear_col_ready", 128'(col_ready), 128'd1);
        send_block(32'haabbccdd, 32'h0, 32'h0, 32'h0, ExpDia, 1'b1);
        drain();

        // Asynchronous reset during HOLD.
        state_ready = 1'b0;
        send_block(32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f, ExpT1, 1'b0);
        check("prerst_valid", 128'(state_valid), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state_valid", 128'(state_valid), 128'd0);
        check("arst_col_ready", 128'(col_ready), 128'd1);
        check("arst_state_out", state_out, 128'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Unstalled stream for throughput.
        state_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
            send_block(r0, r1, r2, r3, model(r0, r1, r2, r3), 1'b1);
        end
        drain();
        check("throughput", 128'(hs_interval), 128'(BlockPeriod));

        // Random stalls on both sides.
        blk0 = n_blocks;
        rand_ready = 1'b1;
        for (int b = 0; b < 6; b++) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
            exp_q.push_back(model(r0, r1, r2, r3));
            send_col(r0);
            repeat ($urandom_range(0, 2)) tick();
            send_col(r1);
            send_col(r2);
            repeat ($urandom_range(0, 2)) tick();
            send_col(r3);
        end
        drain();
        check("stream_blocks", 128'(n_blocks - blk0), 128'd6);

`ifdef INV_SHIFT_ROWS_PINGPONG_EN
        // Fourth-column accept coincides with release of the held block.
        state_ready = 1'b0;
        send_block(32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f, ExpT1, 1'b1);
        exp_q.push_back(ExpRep);
        send_col(32'h11223344);
        send_col(32'h11223344);
        send_col(32'h11223344);
        state_ready = 1'b1;
        send_col(32'h11223344);
        check("pp_coinc_valid", 128'(state_valid), 128'd1);
        check("pp_coinc_col_ready", 128'(col_ready), 128'd1);
        check("pp_coinc_out", state_out, ExpRep);
        tick();
        check("pp_coinc_empty", 128'(state_valid), 128'd0);
        drain();
`endif

        check("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
